ysyx_25020051_gpr_sb: RTL and testbench

YSYX_25020051_GPR_SB -- requirements
Module: ysyx_25020051_gpr_sb

---
 rtl/ysyx_25020051_cpu_pkg.sv | 13 +
 rtl/ysyx_25020051_rf_array.sv | 46 ++++
 rtl/ysyx_25020051_gpr_sb.sv | 114 +++++++++++
 tb/tb_ysyx_25020051_gpr_sb.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25020051_cpu_pkg.sv
// Shared CPU constants: default register-file geometry and a helper that
// turns an index width into a register count.
package ysyx_25020051_cpu_pkg;

   localparam int unsigned CPU_ADDR_WIDTH = 5;
   localparam int unsigned CPU_DATA_WIDTH = 32;
   localparam int unsigned CPU_NREG       = 2 ** CPU_ADDR_WIDTH;

   function automatic int unsigned nreg(input int unsigned aw);
      return 2 ** aw;
   endfunction

endpackage

// File: rtl/ysyx_25020051_rf_array.sv
// General-purpose register storage.
//   clk, rst : clock, asynchronous active-high reset (clears every register)
//   wen      : write enable; waddr/wdata written at the rising edge
//   raddr    : NREAD packed read indices, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   rdata    : NREAD packed asynchronous read values, same packing
// Index 0 is never written and always reads as zero.
module ysyx_25020051_rf_array
   import ysyx_25020051_cpu_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = CPU_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = CPU_DATA_WIDTH,
   parameter int unsigned NREAD      = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wen,
   input  logic [ADDR_WIDTH-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0]         wdata,
   input  logic [NREAD*ADDR_WIDTH-1:0]   raddr,
   output logic [NREAD*DATA_WIDTH-1:0]   rdata
);

   localparam int unsigned NREG = nreg(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] regs [NREG];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wen && (waddr != '0)) begin
         regs[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata = '0;
      for (int unsigned k = 0; k < NREAD; k++) begin
         if (raddr[k*ADDR_WIDTH +: ADDR_WIDTH] != '0) begin
            rdata[k*DATA_WIDTH +: DATA_WIDTH] = regs[raddr[k*ADDR_WIDTH +: ADDR_WIDTH]];
         end
      end
   end

endmodule

// File: rtl/ysyx_25020051_gpr_sb.sv
// Register file with scoreboard: tracks pending writes per register, stalls
// issue on RAW/WAW hazards and forwards same-cycle write-back data.
//   clk, rst     : clock, asynchronous active-high reset
//   iss_valid    : instruction presented for issue
//   iss_ready    : no hazard and no flush; independent of iss_valid
//   iss_rs_addr  : NREAD packed source indices
//   iss_rs_used  : per-source "operand consumed" flags
//   iss_rd       : destination index, reserved on issue when iss_rd_wen=1
//   rs_data      : NREAD packed operand values (with write-back bypass)
//   wb_valid/wb_addr/wb_data : write-back, writes array and releases busy
//   flush        : drops all reservations, array untouched
//   busy         : per-register pending-write bits
module ysyx_25020051_gpr_sb
   import ysyx_25020051_cpu_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = CPU_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = CPU_DATA_WIDTH,
   parameter int unsigned NREAD      = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          iss_valid,
   output logic                          iss_ready,
   input  logic [NREAD*ADDR_WIDTH-1:0]   iss_rs_addr,
   input  logic [NREAD-1:0]              iss_rs_used,
   input  logic [ADDR_WIDTH-1:0]         iss_rd,
   input  logic                          iss_rd_wen,
   output logic [NREAD*DATA_WIDTH-1:0]   rs_data,
   input  logic                          wb_valid,
   input  logic [ADDR_WIDTH-1:0]         wb_addr,
   input  logic [DATA_WIDTH-1:0]         wb_data,
   input  logic                          flush,
   output logic [nreg(ADDR_WIDTH)-1:0]   busy
);

   localparam int unsigned NREG = nreg(ADDR_WIDTH);

   logic [NREG-1:0]             busy_q;
   logic [NREG-1:0]             busy_d;
   logic [NREAD*DATA_WIDTH-1:0] arr_rdata;
   logic                        wb_hit;
   logic                        src_stall;
   logic                        waw_stall;
   logic                        fire;

   // Write-backs to x0 are dropped everywhere: no write, no bypass, no release.
   assign wb_hit = wb_valid && (wb_addr != '0);

   ysyx_25020051_rf_array #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .NREAD      (NREAD)
   ) u_rf_array (
      .clk   (clk),
      .rst   (rst),
      .wen   (wb_hit),
      .waddr (wb_addr),
      .wdata (wb_data),
      .raddr (iss_rs_addr),
      .rdata (arr_rdata)
   );

   // Operand bypass; array already returns zero for index 0.
   always_comb begin
      rs_data = arr_rdata;
      for (int unsigned k = 0; k < NREAD; k++) begin
         if (wb_hit && (wb_addr == iss_rs_addr[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
            rs_data[k*DATA_WIDTH +: DATA_WIDTH] = wb_data;
         end
      end
   end

   // A pending register whose write-back arrives this cycle is not a hazard.
   always_comb begin
      src_stall = 1'b0;
      for (int unsigned k = 0; k < NREAD; k++) begin
         if (iss_rs_used[k]
             && (iss_rs_addr[k*ADDR_WIDTH +: ADDR_WIDTH] != '0)
             && busy_q[iss_rs_addr[k*ADDR_WIDTH +: ADDR_WIDTH]]
             && !(wb_hit && (wb_addr == iss_rs_addr[k*ADDR_WIDTH +: ADDR_WIDTH]))) begin
            src_stall = 1'b1;
         end
      end
      waw_stall = iss_rd_wen && (iss_rd != '0) && busy_q[iss_rd]
                  && !(wb_hit && (wb_addr == iss_rd));
      iss_ready = !src_stall && !waw_stall && !flush;
      fire      = iss_valid && iss_ready;
   end

   // Release is applied before reservation so a same-edge set wins.
   always_comb begin
      busy_d = busy_q;
      if (flush) begin
         busy_d = '0;
      end else if (wb_hit) begin
         busy_d[wb_addr] = 1'b0;
      end
      if (fire && iss_rd_wen && (iss_rd != '0)) begin
         busy_d[iss_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy = busy_q;

endmodule

// File: tb/tb_ysyx_25020051_gpr_sb.sv
// Self-checking bench for ysyx_25020051_gpr_sb: directed scenarios followed by
// randomized traffic, checked against a register/busy-bit reference model.
module tb_ysyx_25020051_gpr_sb;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // default-geometry instance
   logic        iss_valid, iss_ready, iss_rd_wen, wb_valid, flush;
   logic [9:0]  iss_rs_addr;
   logic [1:0]  iss_rs_used;
   logic [4:0]  iss_rd, wb_addr;
   logic [31:0] wb_data;
   logic [63:0] rs_data;
   logic [31:0] busy;

   // three-port, 64-bit instance
   logic         w_iss_valid, w_iss_ready, w_iss_rd_wen, w_wb_valid, w_flush;
   logic [14:0]  w_rs_addr;
   logic [2:0]   w_rs_used;
   logic [4:0]   w_iss_rd, w_wb_addr;
   logic [63:0]  w_wb_data;
   logic [191:0] w_rs_data;
   logic [31:0]  w_busy;

   ysyx_25020051_gpr_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NREAD(2)) dut (
      .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_ready(iss_ready),
      .iss_rs_addr(iss_rs_addr), .iss_rs_used(iss_rs_used), .iss_rd(iss_rd),
      .iss_rd_wen(iss_rd_wen), .rs_data(rs_data), .wb_valid(wb_valid),
      .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush), .busy(busy)
   );

   ysyx_25020051_gpr_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(64), .NREAD(3)) dut_wide (
      .clk(clk), .rst(rst), .iss_valid(w_iss_valid), .iss_ready(w_iss_ready),
      .iss_rs_addr(w_rs_addr), .iss_rs_used(w_rs_used), .iss_rd(w_iss_rd),
      .iss_rd_wen(w_iss_rd_wen), .rs_data(w_rs_data), .wb_valid(w_wb_valid),
      .wb_addr(w_wb_addr), .wb_data(w_wb_data), .flush(w_flush), .busy(w_busy)
   );

   int checks = 0;
   int errors = 0;

   // reference model of the default instance
   logic [31:0] m_regs [32];
   logic [31:0] m_busy;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_busy = '0;
   endtask

   function automatic logic wb_releases(input logic [4:0] a);
      return wb_valid && (wb_addr != 0) && (wb_addr == a);
   endfunction

   function automatic logic exp_ready();
      logic       r;
      logic [4:0] a;
      r = !flush;
      for (int k = 0; k < 2; k++) begin
         a = iss_rs_addr[k*5 +: 5];
         if (iss_rs_used[k] && (a != 0) && m_busy[a] && !wb_releases(a)) r = 1'b0;
      end
      if (iss_rd_wen && (iss_rd != 0) && m_busy[iss_rd] && !wb_releases(iss_rd)) r = 1'b0;
      return r;
   endfunction

   function automatic logic [31:0] exp_rs(input int k);
      logic [4:0] a;
      a = iss_rs_addr[k*5 +: 5];
      if (a == 0) return 32'h0;
      if (wb_releases(a)) return wb_data;
      return m_regs[a];
   endfunction

   task automatic check_outputs();
      chk("iss_ready", iss_ready, exp_ready());
      chk("rs_data0", rs_data[31:0], exp_rs(0));
      chk("rs_data1", rs_data[63:32], exp_rs(1));
      chk("busy", busy, m_busy);
   endtask

   // apply the current inputs to the model, then cross one rising edge
   task automatic advance();
      logic        fire;
      logic [31:0] nb;
      fire = iss_valid && exp_ready();
      nb   = m_busy;
      if (wb_valid && (wb_addr != 0)) m_regs[wb_addr] = wb_data;
      if (flush) nb = '0;
      else if (wb_valid && (wb_addr != 0)) nb[wb_addr] = 1'b0;
      if (fire && iss_rd_wen && (iss_rd != 0)) nb[iss_rd] = 1'b1;
      m_busy = nb;
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      #1;
      check_outputs();
      advance();
   endtask

   task automatic idle();
      iss_valid = 0; iss_rs_addr = '0; iss_rs_used = '0; iss_rd = '0; iss_rd_wen = 0;
      wb_valid = 0; wb_addr = '0; wb_data = '0; flush = 0;
   endtask

   task automatic w_idle();
      w_iss_valid = 0; w_rs_addr = '0; w_rs_used = '0; w_iss_rd = '0; w_iss_rd_wen = 0;
      w_wb_valid = 0; w_wb_addr = '0; w_wb_data = '0; w_flush = 0;
   endtask

   task automatic issue_rd(input logic [4:0] rd);
      idle(); iss_valid = 1; iss_rd = rd; iss_rd_wen = 1;
      step();
   endtask

   task automatic write_back(input logic [4:0] a, input logic [31:0] d);
      idle(); wb_valid = 1; wb_addr = a; wb_data = d;
      step();
   endtask

   function automatic logic [4:0] rnd_addr();
      if ($urandom % 4 == 0) return 5'($urandom_range(0, 31));
      return 5'($urandom_range(0, 7));
   endfunction

   initial begin
      idle(); w_idle(); model_reset();
      rst = 1;
      #2;
      chk("rst_busy", busy, 32'h0);
      chk("rst_ready", iss_ready, 1'b1);
      repeat (2) @(posedge clk);
      #1; rst = 0;

      // all registers read zero after reset
      for (int i = 0; i < 32; i++) begin
         idle();
         iss_rs_addr = {5'(31 - i), 5'(i)};
         step();
      end

      // RAW stall released by same-cycle write-back with bypass
      issue_rd(5'd1);
      idle(); iss_valid = 1; iss_rs_addr[4:0] = 5'd1; iss_rs_used = 2'b01;
      #1;
      chk("raw_stall", iss_ready, 1'b0);
      wb_valid = 1; wb_addr = 5'd1; wb_data = 32'd5;
      #1;
      chk("raw_release_ready", iss_ready, 1'b1);
      chk("raw_bypass_data", rs_data[31:0], 32'd5);
      check_outputs();
      advance();

      // WAW stall; write-back and re-issue on the same edge keeps x3 busy
      issue_rd(5'd3);
      idle(); iss_valid = 1; iss_rd = 5'd3; iss_rd_wen = 1;
      #1;
      chk("waw_stall", iss_ready, 1'b0);
      wb_valid = 1; wb_addr = 5'd3; wb_data = 32'h10;
      #1;
      chk("waw_release_ready", iss_ready, 1'b1);
      check_outputs();
      advance();
      chk("waw_busy3", busy[3], 1'b1);
      idle(); iss_rs_addr[4:0] = 5'd3;
      #1;
      chk("waw_x3", rs_data[31:0], 32'h10);
      check_outputs();
      advance();

      // flush drops reservations but keeps data
      write_back(5'd2, 32'h22);
      write_back(5'd4, 32'h44);
      issue_rd(5'd2);
      issue_rd(5'd4);
      idle(); flush = 1;
      #1;
      chk("flush_ready", iss_ready, 1'b0);
      check_outputs();
      advance();
      chk("flush_busy", busy, 32'h0);
      idle(); iss_rs_addr = {5'd4, 5'd2};
      #1;
      chk("flush_x2", rs_data[31:0], 32'h22);
      chk("flush_x4", rs_data[63:32], 32'h44);
      check_outputs();
      advance();

      // write-back to x0 is ignored
      idle(); wb_valid = 1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF; iss_rs_used = 2'b11;
      #1;
      chk("x0_bypass", rs_data[31:0], 32'h0);
      check_outputs();
      advance();
      chk("x0_busy", busy[0], 1'b0);
      idle();
      step();

      // three ports, 64-bit data
      w_idle(); w_wb_valid = 1; w_wb_addr = 5'd5; w_wb_data = 64'h12_3456_789A;
      @(posedge clk); #1;
      w_idle(); w_rs_addr = {5'd5, 5'd5, 5'd5};
      #1;
      chk("wide_port0", w_rs_data[63:0],    64'h12_3456_789A);
      chk("wide_port1", w_rs_data[127:64],  64'h12_3456_789A);
      chk("wide_port2", w_rs_data[191:128], 64'h12_3456_789A);
      w_idle(); w_iss_valid = 1; w_iss_rd = 5'd6; w_iss_rd_wen = 1;
      @(posedge clk); #1;
      w_idle();
      chk("wide_busy6", w_busy[6], 1'b1);
      w_iss_valid = 1; w_rs_addr[4:0] = 5'd6; w_rs_used = 3'b001;
      // put the default instance into a stall as well
      issue_rd(5'd7);
      idle(); iss_valid = 1; iss_rs_addr[4:0] = 5'd7; iss_rs_used = 2'b01;
      #1;
      chk("wide_stall", w_iss_ready, 1'b0);
      chk("mid_stall", iss_ready, 1'b0);

      // asynchronous reset mid-stall; write-backs during reset are dropped
      rst = 1;
      model_reset();
      #1;
      chk("async_wide_busy", w_busy, 32'h0);
      chk("async_wide_ready", w_iss_ready, 1'b1);
      chk("async_busy", busy, 32'h0);
      chk("async_ready", iss_ready, 1'b1);
      idle(); wb_valid = 1; wb_addr = 5'd9; wb_data = 32'hDEAD_BEEF;
      w_idle(); w_wb_valid = 1; w_wb_addr = 5'd5; w_wb_data = 64'hFFFF;
      @(posedge clk); #1;
      idle(); w_idle();
      rst = 0;
      w_rs_addr = {5'd0, 5'd0, 5'd5};
      iss_rs_addr = {5'd5, 5'd9};
      #1;
      chk("rst_wide_x5", w_rs_data[63:0], 64'h0);
      chk("rst_x9", rs_data[31:0], 32'h0);
      step();

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         iss_valid   = ($urandom % 4) != 0;
         iss_rs_addr = {rnd_addr(), rnd_addr()};
         iss_rs_used = 2'($urandom);
         iss_rd      = rnd_addr();
         iss_rd_wen  = 1'($urandom);
         wb_valid    = 1'($urandom);
         wb_addr     = rnd_addr();
         wb_data     = $urandom;
         flush       = ($urandom % 16) == 0;
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
